// File: rtl/cv4_pkg.sv
// Shared types and helpers for the CV4 frame sequencer.
// Holds the FSM state encoding and the per-frame output-count helper.
package cv4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KLOAD,
      ST_KFLUSH,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } cv4_state_e;

   // Valid (non-padded) convolution outputs produced per streamed frame.
   function automatic int n_out(input int img_cols, input int kernel_size);
      return img_cols - kernel_size + 1;
   endfunction

endpackage

// File: rtl/cv4_seq_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag
// that is high while the count equals the compile-time terminal value.
module cv4_seq_counter #(
   parameter int WIDTH = 4,
   parameter int TERM  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             term_o
);

   localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign term_o = (cnt_q == TERM_V);

endmodule

// File: rtl/cv4_sequencer.sv
// Frame sequencer for the CV4 column filter: loads the kernel, streams image
// columns, counts filter outputs. Define CV4_SEQ_TIMEOUT_EN for a drain watchdog.
module cv4_sequencer import cv4_pkg::*; #(
   parameter int KERNEL_SIZE    = 4,
   parameter int IMG_COLS       = 12,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          kern_rd_en,
   output logic [$clog2(KERNEL_SIZE)-1:0] kern_addr,
   input  logic                          col_valid,
   output logic                          col_ready,
   output logic                          flt_clr,
   output logic                          flt_kernel_load,
   output logic                          flt_valid_in,
   input  logic                          flt_valid_out,
   output logic [$clog2(IMG_COLS)-1:0]   out_col_idx,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int KW   = $clog2(KERNEL_SIZE);
   localparam int CW   = $clog2(IMG_COLS + 1);
   localparam int IW   = $clog2(IMG_COLS);
   localparam int NOUT = n_out(IMG_COLS, KERNEL_SIZE);

   cv4_state_e state_q;
   logic       flt_clr_q;
   logic       kload_q;

   logic          frame_go;
   logic          xfer;
   logic          out_en;
   logic [KW-1:0] k_cnt;
   logic          k_last;
   logic [CW-1:0] col_cnt;
   logic          col_last;
   logic [CW-1:0] out_cnt;
   logic          out_all;

   assign frame_go = (state_q == ST_IDLE) && start;
   assign xfer     = col_valid && col_ready;
   assign out_en   = flt_valid_out && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));

   cv4_seq_counter #(.WIDTH(KW), .TERM(KERNEL_SIZE - 1)) u_kern_cnt (
      .clk(clk), .rst(rst), .clr_i(frame_go), .en_i(state_q == ST_KLOAD),
      .cnt_o(k_cnt), .term_o(k_last)
   );

   cv4_seq_counter #(.WIDTH(CW), .TERM(IMG_COLS - 1)) u_col_cnt (
      .clk(clk), .rst(rst), .clr_i(frame_go), .en_i(xfer),
      .cnt_o(col_cnt), .term_o(col_last)
   );

   cv4_seq_counter #(.WIDTH(CW), .TERM(NOUT)) u_out_cnt (
      .clk(clk), .rst(rst), .clr_i(frame_go), .en_i(out_en),
      .cnt_o(out_cnt), .term_o(out_all)
   );

`ifdef CV4_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          err_q;
   logic          wd_expired;
   logic [TW-1:0] wd_cnt_unused;

   // Restarts on every filter output so only a stalled drain trips it.
   cv4_seq_counter #(.WIDTH(TW), .TERM(TIMEOUT_CYCLES)) u_wd_cnt (
      .clk(clk), .rst(rst), .clr_i((state_q != ST_DRAIN) || flt_valid_out), .en_i(1'b1),
      .cnt_o(wd_cnt_unused), .term_o(wd_expired)
   );

   assign err = err_q;
`else
   localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;

   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         flt_clr_q <= 1'b0;
         kload_q   <= 1'b0;
`ifdef CV4_SEQ_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         flt_clr_q <= frame_go;
         // ROM data lags the read strobe by one cycle, so the load follows it.
         kload_q   <= kern_rd_en;
`ifdef CV4_SEQ_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
         case (state_q)
            ST_IDLE:   if (start) state_q <= ST_KLOAD;
            ST_KLOAD:  if (k_last) state_q <= ST_KFLUSH;
            ST_KFLUSH: state_q <= ST_STREAM;
            ST_STREAM: if (xfer && col_last) state_q <= ST_DRAIN;
            ST_DRAIN: begin
               if (out_all) begin
                  state_q <= ST_DONE;
`ifdef CV4_SEQ_TIMEOUT_EN
               end else if (wd_expired) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
`endif
               end
            end
            ST_DONE:   state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   assign kern_rd_en      = (state_q == ST_KLOAD);
   assign kern_addr       = k_cnt;
   assign col_ready       = (state_q == ST_STREAM) && (col_cnt < CW'(IMG_COLS));
   assign flt_valid_in    = xfer;
   assign flt_clr         = flt_clr_q;
   assign flt_kernel_load = kload_q;
   assign out_col_idx     = out_cnt[IW-1:0];
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);

endmodule

// File: doc/cv4_sequencer.md
CV4_SEQUENCER -- requirements
Module: cv4_sequencer

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 4, kernel columns loaded per frame and minimum columns before the first output.
REQ-002 SHALL have parameter IMG_COLS, default 12, image columns streamed per frame (>= KERNEL_SIZE).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, drain watchdog limit.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle frame request.
REQ-007 SHALL have port kern_rd_en  out  1  kernel ROM read strobe; ROM data valid the next cycle.
REQ-008 SHALL have port kern_addr  out  $clog2(KERNEL_SIZE)  kernel column address.
REQ-009 SHALL have port col_valid  in  1  upstream image column available.
REQ-010 SHALL have port col_ready  out  1  sequencer accepts a column; transfer = col_valid && col_ready.
REQ-011 SHALL have port flt_clr  out  1  filter pipeline clear pulse; the integrator ORs it into the filter reset.
REQ-012 SHALL have port flt_kernel_load  out  1  filter kernel-load control.
REQ-013 SHALL have port flt_valid_in  out  1  filter column-valid control.
REQ-014 SHALL have port flt_valid_out  in  1  filter output-valid.
REQ-015 SHALL have port out_col_idx  out  $clog2(IMG_COLS)  index of the current output column, valid with flt_valid_out.
REQ-016 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (one-cycle pulse).

Function
REQ-017 The FSM SHALL have states IDLE, KLOAD, KFLUSH, STREAM, DRAIN and DONE.
REQ-018 IDLE: on start, SHALL pulse flt_clr for 1 cycle, zero all counters and enter KLOAD.
REQ-019 KLOAD: SHALL assert kern_rd_en with kern_addr 0..KERNEL_SIZE-1 on consecutive cycles, then enter KFLUSH.
REQ-020 flt_kernel_load SHALL equal kern_rd_en delayed 1 cycle, giving exactly KERNEL_SIZE cycles aligned with ROM data.
REQ-021 KFLUSH: SHALL last 1 cycle (last kernel column lands), then enter STREAM.
REQ-022 STREAM: col_ready SHALL be 1 while col_cnt < IMG_COLS.
REQ-023 STREAM: flt_valid_in SHALL be col_valid && col_ready, combinational.
REQ-024 STREAM: col_cnt SHALL increment on each transfer; after transfer IMG_COLS the FSM SHALL enter DRAIN.
REQ-025 out_cnt SHALL increment on flt_valid_out in STREAM or DRAIN, and out_col_idx SHALL equal out_cnt.
REQ-026 flt_valid_out outside STREAM/DRAIN SHALL be ignored.
REQ-027 Expected outputs per frame N_OUT = IMG_COLS-KERNEL_SIZE+1; the first output arrives 2 cycles after transfer KERNEL_SIZE.
REQ-028 DRAIN: SHALL wait until out_cnt == N_OUT, then enter DONE.
REQ-029 DONE: SHALL pulse done for 1 cycle, then return to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored; start coincident with the DONE cycle SHALL be ignored.
REQ-032 col_valid in any state other than STREAM SHALL see col_ready=0.
REQ-033 flt_kernel_load and flt_valid_in SHALL never be 1 in the same cycle.

Reset
REQ-034 rst SHALL force IDLE and zero all counters at any time, including mid-frame.
REQ-035 During reset, all outputs SHALL be 0, and out_col_idx SHALL be 0.
REQ-036 No flt_clr pulse SHALL be generated by reset itself.

Configuration
REQ-037 With CV4_SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles in DRAIN since the last flt_valid_out.
REQ-038 When that count reaches TIMEOUT_CYCLES, SHALL pulse err for 1 cycle and return to IDLE without pulsing done.
REQ-039 Without CV4_SEQ_TIMEOUT_EN, err SHALL be tied 0 and DRAIN SHALL wait indefinitely.

Structure
REQ-040 Package cv4_pkg SHALL hold the state enum and a function n_out(img_cols, kernel_size).
REQ-041 Sub-module cv4_seq_counter (parameterised width, clear, enable, terminal-value flag) SHALL be instantiated for the kernel, column, output and watchdog counters.

Verification
REQ-042 Reset then start, col_valid held 1 -> 4 flt_kernel_load cycles (addr 0..3), then 12 flt_valid_in cycles, 9 outputs with idx 0..8, done exactly once.
REQ-043 col_valid toggling 1/0 every cycle -> flt_valid_in only on transfers, col_cnt reaches 12, 9 outputs, done asserted.
REQ-044 start pulsed during STREAM -> no effect, single done; a second start after done -> flt_clr pulse and a full correct frame.
REQ-045 rst asserted after the 6th column -> all outputs 0 immediately, FSM in IDLE, next frame correct.
REQ-046 CV4_SEQ_TIMEOUT_EN defined, filter stops after 5 outputs -> err after 64 idle DRAIN cycles, no done; undefined -> busy stays 1.
